// File: rtl/alu32_sequencer.sv
// alu32_sequencer: accepts one ALU command at a time, drives alu32 through
// issue / wait / clear, keeps the one-cycle-late feedback registers alu32
// expects, and returns the captured results (or a timeout error) on a
// valid/ready response port. All outputs come straight from flops.
module alu32_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result1,
  output logic [31:0] rsp_result2,
  output logic [3:0]  rsp_opcode,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_op_start,
  output logic        alu_op_clear,
  output logic [1:0]  alu_op_done_before,
  output logic [31:0] alu_result1_before,
  output logic [31:0] alu_result2_before,
  input  logic [31:0] alu_result1,
  input  logic [31:0] alu_result2,
  input  logic [1:0]  alu_op_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  // Only 11 means done; 01 falls through and is treated like busy.
  localparam logic [1:0] DONE_CODE = 2'b11;
  // The counter starts at 0 on the first WAIT cycle, so the cycle on which it
  // would step to TIMEOUT-1 is the last one allowed to complete.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              cmd_ready_s, rsp_valid_s, rsp_err_s;
  logic              start_s, clear_s;
  logic [31:0]       a_s, b_s, res1_s, res2_s, fb_res1_s, fb_res2_s;
  logic [3:0]        op_s, rsp_op_s;
  logic [1:0]        fb_done_s;

  // Next-state and next-output decode; every register holds unless a state
  // below changes it, and the feedback registers follow alu32 by default.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cmd_ready_s = 1'b0;
    a_s         = alu_a;
    b_s         = alu_b;
    op_s        = alu_opcode;
    start_s     = alu_op_start;
    clear_s     = 1'b0;
    fb_done_s   = alu_op_done;
    fb_res1_s   = alu_result1;
    fb_res2_s   = alu_result2;
    rsp_valid_s = rsp_valid;
    res1_s      = rsp_result1;
    res2_s      = rsp_result2;
    rsp_op_s    = rsp_opcode;
    rsp_err_s   = rsp_err;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_s       = cmd_a;
          b_s       = cmd_b;
          op_s      = cmd_opcode;
          start_s   = 1'b1;
          fb_done_s = 2'b00;
          cnt_s     = {CNT_W{1'b0}};
          state_s   = ST_ISSUE;
        end else begin
          cmd_ready_s = 1'b1;
          start_s     = 1'b0;
        end
      end
      ST_ISSUE: begin
        start_s = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (alu_op_done == DONE_CODE) begin
          res1_s      = alu_result1;
          res2_s      = alu_result2;
          rsp_op_s    = alu_opcode;
          rsp_err_s   = 1'b0;
          rsp_valid_s = 1'b1;
          start_s     = 1'b0;
          state_s     = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          res1_s      = 32'h0000_0000;
          res2_s      = 32'h0000_0000;
          rsp_op_s    = alu_opcode;
          rsp_err_s   = 1'b1;
          rsp_valid_s = 1'b1;
          start_s     = 1'b0;
          state_s     = ST_RESP;
        end else begin
          start_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          clear_s     = 1'b1;
          fb_done_s   = 2'b00;
          state_s     = ST_CLEAR;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_CLEAR: begin
        fb_done_s   = 2'b00;
        cmd_ready_s = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        cmd_ready_s = 1'b1;
        start_s     = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r            <= ST_IDLE;
      cnt_r              <= {CNT_W{1'b0}};
      cmd_ready          <= 1'b1;
      alu_a              <= 32'h0000_0000;
      alu_b              <= 32'h0000_0000;
      alu_opcode         <= 4'h0;
      alu_op_start       <= 1'b0;
      alu_op_clear       <= 1'b0;
      alu_op_done_before <= 2'b00;
      alu_result1_before <= 32'h0000_0000;
      alu_result2_before <= 32'h0000_0000;
      rsp_valid          <= 1'b0;
      rsp_result1        <= 32'h0000_0000;
      rsp_result2        <= 32'h0000_0000;
      rsp_opcode         <= 4'h0;
      rsp_err            <= 1'b0;
    end else begin
      state_r            <= state_s;
      cnt_r              <= cnt_s;
      cmd_ready          <= cmd_ready_s;
      alu_a              <= a_s;
      alu_b              <= b_s;
      alu_opcode         <= op_s;
      alu_op_start       <= start_s;
      alu_op_clear       <= clear_s;
      alu_op_done_before <= fb_done_s;
      alu_result1_before <= fb_res1_s;
      alu_result2_before <= fb_res2_s;
      rsp_valid          <= rsp_valid_s;
      rsp_result1        <= res1_s;
      rsp_result2        <= res2_s;
      rsp_opcode         <= rsp_op_s;
      rsp_err            <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_alu32_sequencer.sv
// Directed bench for alu32_sequencer with a small behavioural alu32 stand-in
// whose busy length is set per test.
module tb_alu32_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_opcode;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result1, rsp_result2;
  logic [3:0]  rsp_opcode;
  logic        rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_op_start, alu_op_clear;
  logic [1:0]  alu_op_done_before;
  logic [31:0] alu_result1_before, alu_result2_before;
  logic [31:0] alu_result1, alu_result2;
  logic [1:0]  alu_op_done;

  int n_cmp = 0;
  int n_err = 0;
  int busy_len = 0;
  int mcnt;
  logic [1:0]  mdone;
  logic [31:0] mres1, mres2;

  assign alu_op_done = mdone;
  assign alu_result1 = mres1;
  assign alu_result2 = mres2;

  alu32_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result1(rsp_result1), .rsp_result2(rsp_result2),
    .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_op_start(alu_op_start), .alu_op_clear(alu_op_clear),
    .alu_op_done_before(alu_op_done_before),
    .alu_result1_before(alu_result1_before),
    .alu_result2_before(alu_result2_before),
    .alu_result1(alu_result1), .alu_result2(alu_result2),
    .alu_op_done(alu_op_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Stand-in ALU arithmetic: {result2, result1}.
  function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'h2:    alu_fn = {32'h0, a & b};
      4'hC:    alu_fn = {32'h0, a - b};
      4'hD:    alu_fn = {32'h0, a} * {32'h0, b};
      default: alu_fn = {32'h0, a ^ b};
    endcase
  endfunction

  // Stand-in alu32: 0 busy cycles answers next cycle, otherwise 10 for busy_len cycles.
  always @(posedge clk) begin
    if (!reset_n) begin
      mdone <= 2'b00;
      mcnt  <= 0;
      mres1 <= 32'h0;
      mres2 <= 32'h0;
    end else if (alu_op_clear) begin
      mdone <= 2'b00;
      mcnt  <= 0;
    end else if (mdone == 2'b00 && alu_op_start && alu_op_done_before != 2'b11) begin
      if (busy_len == 0) begin
        mdone          <= 2'b11;
        {mres2, mres1} <= alu_fn(alu_a, alu_b, alu_opcode);
      end else begin
        mdone <= 2'b10;
        mcnt  <= 1;
      end
    end else if (mdone == 2'b10) begin
      if (mcnt == busy_len) begin
        mdone          <= 2'b11;
        {mres2, mres1} <= alu_fn(alu_a, alu_b, alu_opcode);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in IDLE; returns in the ISSUE cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
    check_eq("cmd_ready_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Count edges from the current cycle until rsp_valid, bounded by max.
  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  // Let an accepted response go through CLEAR back to IDLE.
  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    check_eq("clear_pulse", alu_op_clear, 1'b1);
    tick();
  endtask

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int busy_seen;
    logic [1:0] prev;

    // Reset with a command already waiting.
    reset_n = 1'b0; rsp_ready = 1'b1; busy_len = 0;
    cmd_valid = 1'b1; cmd_a = 32'h0000_1000; cmd_b = 32'h0010_1000; cmd_opcode = 4'h2;
    repeat (2) tick();
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_outs", {rsp_valid, alu_op_start, alu_op_clear, rsp_err}, 4'b0000);
    check_eq("rst_fb", {alu_op_done_before, alu_result1_before, alu_result2_before}, 66'h0);
    check_eq("rst_alu_a", alu_a, 32'h0);

    // AND: accepted on the first edge after reset release.
    reset_n = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_eq("and_issue_start", {alu_op_start, cmd_ready}, 2'b10);
    check_eq("and_issue_ops", {alu_a, alu_b}, {32'h0000_1000, 32'h0010_1000});
    check_eq("and_issue_opc", alu_opcode, 4'h2);
    check_eq("and_issue_fb", alu_op_done_before, 2'b00);
    tick();
    check_eq("and_wait", {alu_op_start, rsp_valid}, 2'b10);
    tick();
    check_eq("and_rsp_valid", {rsp_valid, rsp_err, alu_op_start}, 3'b100);
    check_eq("and_result1", rsp_result1, 32'h0000_1000);
    check_eq("and_opcode", rsp_opcode, 4'h2);
    tick();
    check_eq("and_clear", {alu_op_clear, rsp_valid, cmd_ready}, 3'b100);
    check_eq("and_clear_fb", alu_op_done_before, 2'b00);
    tick();
    check_eq("and_ready_back", {cmd_ready, alu_op_clear}, 2'b10);

    // MUL with 32 busy cycles, then 10 cycles of backpressure.
    busy_len = 32; rsp_ready = 1'b0;
    issue(32'h0000_1000, 32'h0010_1000, 4'hD);
    prev = alu_op_done;
    busy_seen = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
      check_eq("mul_ops", {alu_a, alu_b}, {32'h0000_1000, 32'h0010_1000});
      check_eq("mul_fb_track", alu_op_done_before, prev);
      if (alu_op_done_before == 2'b10) busy_seen++;
      prev = alu_op_done;
    end
    check_eq("mul_latency", n, 34);
    check_eq("mul_busy_cycles", busy_seen, 32);
    // 0x1000 * 0x101000 = 0x1_0100_0000
    check_eq("mul_results", {rsp_result2, rsp_result1}, 64'h0000_0001_0100_0000);
    check_eq("mul_err_opc", {rsp_err, rsp_opcode}, 5'h0D);
    check_eq("mul_fb_result1", alu_result1_before, 32'h0100_0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_ctrl", {rsp_valid, cmd_ready, alu_op_start, alu_op_clear}, 4'b1000);
      check_eq("bp_results", {rsp_result2, rsp_result1}, 64'h0000_0001_0100_0000);
      check_eq("bp_opcode", rsp_opcode, 4'hD);
    end
    drain();

    // Illegal opcode: alu never finishes, abort after 64 cycles from ISSUE.
    busy_len = 1000;
    issue(32'h0000_0011, 32'h0000_0022, 4'hE);
    wait_rsp(80, n);
    check_eq("to_latency", n, 64);
    check_eq("to_err", {rsp_valid, rsp_err}, 2'b11);
    check_eq("to_results", {rsp_result2, rsp_result1}, 64'h0);
    check_eq("to_opcode", rsp_opcode, 4'hE);
    drain();

    // Done arrives on the last allowed WAIT cycle: done wins.
    busy_len = 62;
    issue(32'hF0F0_1234, 32'hFF00_FF00, 4'h2);
    wait_rsp(80, n);
    check_eq("tie_latency", n, 64);
    check_eq("tie_err", {rsp_valid, rsp_err}, 2'b10);
    check_eq("tie_result1", rsp_result1, 32'hF000_1200);
    drain();

    // Done one cycle too late: still a timeout.
    busy_len = 63;
    issue(32'hF0F0_1234, 32'hFF00_FF00, 4'h2);
    wait_rsp(80, n);
    check_eq("late_latency", n, 64);
    check_eq("late_err", {rsp_valid, rsp_err}, 2'b11);
    check_eq("late_result1", rsp_result1, 32'h0);
    drain();

    // Reset in the middle of a MUL wait.
    busy_len = 32;
    issue(32'h0000_1000, 32'h0010_1000, 4'hD);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    check_eq("mrst_ctrl", {cmd_ready, alu_op_start, rsp_valid}, 3'b100);
    check_eq("mrst_fb", alu_op_done_before, 2'b00);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mrst_no_rsp", {rsp_valid, alu_op_start}, 2'b00);
    end

    // SUB after the reset.
    busy_len = 0;
    issue(32'd5, 32'd3, 4'hC);
    wait_rsp(10, n);
    check_eq("sub_latency", n, 2);
    check_eq("sub_result1", rsp_result1, 32'd2);
    check_eq("sub_err_opc", {rsp_err, rsp_opcode}, 5'h0C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
